// File: rtl/truth_table_scanner.sv
// Exhaustive stimulus/compare stage for a small combinational block: walks every input
// vector, samples the response and records mismatches. Optional: TT_SCAN_STOP_ON_ERR_EN.
module truth_table_scanner #(
   parameter int                     N_IN          = 3,
   parameter logic [(2**N_IN)-1:0]   REF_TABLE     = 8'h36,
   parameter int                     SETTLE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start_i,
   output logic [N_IN-1:0]       vec_o,
   input  logic                  dut_r_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [(2**N_IN)-1:0]  mismatch_mask_o,
   output logic [N_IN:0]         err_cnt_o,
   output logic                  first_err_vld_o,
   output logic [N_IN-1:0]       first_err_idx_o
);

   localparam logic [N_IN-1:0] LAST_IDX = '1;
   localparam logic [7:0]      SETTLE   = 8'(SETTLE_CYCLES);

`ifdef TT_SCAN_STOP_ON_ERR_EN
   localparam logic STOP_ON_ERR = 1'b1;
`else
   localparam logic STOP_ON_ERR = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, DONE} state_t;

   state_t                 state_q, state_d;
   logic [N_IN-1:0]        vec_q, vec_d;
   logic [7:0]             cnt_q, cnt_d;
   logic [(2**N_IN)-1:0]   mask_q, mask_d;
   logic [N_IN:0]          err_q, err_d;
   logic                   vld_q, vld_d;
   logic [N_IN-1:0]        idx_q, idx_d;
   logic                   mismatch;

   // Case inequality so an X/Z response is reported as a failure rather than masked.
   assign mismatch = (dut_r_i !== REF_TABLE[vec_q]);

   // A vector is sampled after SETTLE hold cycles; with no settle time HOLD is skipped.
   function automatic state_t first_wait_state();
      return (SETTLE == 8'd0) ? SAMPLE : HOLD;
   endfunction

   // NOTE: every *_d gets a default (its current value) first, so no path through the
   // case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      mask_d  = mask_q;
      err_d   = err_q;
      vld_d   = vld_q;
      idx_d   = idx_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               vec_d   = '0;
               cnt_d   = SETTLE;
               mask_d  = '0;
               err_d   = '0;
               vld_d   = 1'b0;
               idx_d   = '0;
               state_d = first_wait_state();
            end
         end

         HOLD: begin
            if (cnt_q <= 8'd1) begin
               cnt_d   = 8'd0;
               state_d = SAMPLE;
            end else begin
               cnt_d   = cnt_q - 8'd1;
            end
         end

         SAMPLE: begin
            if (mismatch) begin
               mask_d[vec_q] = 1'b1;
               err_d         = err_q + 1'b1;
               if (!vld_q) begin
                  vld_d = 1'b1;
                  idx_d = vec_q;
               end
            end
            if (vec_q == LAST_IDX || (STOP_ON_ERR && mismatch)) begin
               state_d = DONE;
            end else begin
               vec_d   = vec_q + 1'b1;
               cnt_d   = SETTLE;
               state_d = first_wait_state();
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         mask_q  <= '0;
         err_q   <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         mask_q  <= mask_d;
         err_q   <= err_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
      end
   end

   assign vec_o           = vec_q;
   assign busy_o          = (state_q == HOLD) || (state_q == SAMPLE);
   assign done_o          = (state_q == DONE);
   assign mismatch_mask_o = mask_q;
   assign err_cnt_o       = err_q;
   assign first_err_vld_o = vld_q;
   assign first_err_idx_o = idx_q;

endmodule
